// File: rtl/regfile_writeback_scheduler.sv
// Arbitrates the register file's single write port between ALU results and load returns,
// and tracks registers with pending loads so the issue stage can stall on them.
module regfile_writeback_scheduler #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_WIDTH    = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cAluValid,
  input  logic [ADDR_WIDTH-1:0] cAluAddress,
  input  logic [DATA_WIDTH-1:0] cAluData,
  output logic                  hAluReady,
  input  logic                  cMemValid,
  input  logic [ADDR_WIDTH-1:0] cMemAddress,
  input  logic [DATA_WIDTH-1:0] cMemData,
  output logic                  hMemReady,
  input  logic                  cMarkValid,
  input  logic [ADDR_WIDTH-1:0] cMarkAddress,
  input  logic [ADDR_WIDTH-1:0] cReg1Address,
  input  logic [ADDR_WIDTH-1:0] cReg2Address,
  output logic                  hReg1Busy,
  output logic                  hReg2Busy,
  output logic [ADDR_WIDTH-1:0] cRegDAddress,
  output logic [DATA_WIDTH-1:0] cRegDData,
  output logic                  hError
);

  localparam int NumRegs = 2 ** ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] Limit = CNT_WIDTH'(STARVE_LIMIT);

  logic [CNT_WIDTH-1:0] starveCount;
  logic [NumRegs-1:0]   busy;
  logic [NumRegs-1:0]   busyNext;
  logic [NumRegs-1:0]   setVec;
  logic [NumRegs-1:0]   clearVec;
  logic                 outIsMem;
  logic                 forceAlu;
  logic                 aluGrant;
  logic                 memGrant;
  logic                 markError;
  logic                 commitError;

  // NOTE: every combinational output gets a default before any branch so no latch is inferred.
  always_comb begin
    hAluReady = 1'b0;
    hMemReady = 1'b0;
    forceAlu  = (STARVE_LIMIT != 0) && (starveCount == Limit);
    if (!reset) begin
      if (forceAlu) begin
        hAluReady = 1'b1;
        hMemReady = !cAluValid;
      end else begin
        hMemReady = cMemValid;
        hAluReady = !cMemValid;
      end
    end
  end

  assign aluGrant = cAluValid && hAluReady;
  assign memGrant = cMemValid && hMemReady;

  // A clear lands on the edge the register file commits the load; a same-edge mark wins.
  always_comb begin
    setVec   = '0;
    clearVec = '0;
    if (cMarkValid) setVec[cMarkAddress] = 1'b1;
    setVec[0] = 1'b0;
    if (outIsMem) clearVec[cRegDAddress] = 1'b1;
    busyNext    = (busy & ~clearVec) | setVec;
    markError   = cMarkValid && (cMarkAddress != '0) && busy[cMarkAddress]
                  && !clearVec[cMarkAddress];
    commitError = outIsMem && !busy[cRegDAddress];
  end

  assign hReg1Busy = (cReg1Address != '0) && busy[cReg1Address];
  assign hReg2Busy = (cReg2Address != '0) && busy[cReg2Address];

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the busy vector is a small flop array read combinationally, so it is reset like any other state.
  always_ff @(posedge clock) begin
    if (reset) begin
      starveCount  <= '0;
      busy         <= '0;
      outIsMem     <= 1'b0;
      cRegDAddress <= '0;
      cRegDData    <= '0;
      hError       <= 1'b0;
    end else begin
      if (!cAluValid || aluGrant) begin
        starveCount <= '0;
      end else if (starveCount != Limit) begin
        starveCount <= starveCount + 1'b1;
      end

      if (aluGrant) begin
        cRegDAddress <= cAluAddress;
        cRegDData    <= cAluData;
        outIsMem     <= 1'b0;
      end else if (memGrant) begin
        cRegDAddress <= cMemAddress;
        cRegDData    <= cMemData;
        outIsMem     <= (cMemAddress != '0);
      end else begin
        cRegDAddress <= '0;
        outIsMem     <= 1'b0;
      end

      busy <= busyNext;
      if (markError || commitError) hError <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_writeback_scheduler.sv
// Randomized and directed bench for regfile_writeback_scheduler against a cycle-level
// behavioural model (arrays of busy flags, a starvation count and a pending write).
module tb_regfile_writeback_scheduler;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int LIMIT = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          cAluValid;
  logic [AW-1:0] cAluAddress;
  logic [DW-1:0] cAluData;
  logic          hAluReady;
  logic          cMemValid;
  logic [AW-1:0] cMemAddress;
  logic [DW-1:0] cMemData;
  logic          hMemReady;
  logic          cMarkValid;
  logic [AW-1:0] cMarkAddress;
  logic [AW-1:0] cReg1Address;
  logic [AW-1:0] cReg2Address;
  logic          hReg1Busy;
  logic          hReg2Busy;
  logic [AW-1:0] cRegDAddress;
  logic [DW-1:0] cRegDData;
  logic          hError;

  always #5 clock = ~clock;

  regfile_writeback_scheduler #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT), .CNT_WIDTH(3)
  ) dut (
    .clock(clock), .reset(reset),
    .cAluValid(cAluValid), .cAluAddress(cAluAddress), .cAluData(cAluData), .hAluReady(hAluReady),
    .cMemValid(cMemValid), .cMemAddress(cMemAddress), .cMemData(cMemData), .hMemReady(hMemReady),
    .cMarkValid(cMarkValid), .cMarkAddress(cMarkAddress),
    .cReg1Address(cReg1Address), .cReg2Address(cReg2Address),
    .hReg1Busy(hReg1Busy), .hReg2Busy(hReg2Busy),
    .cRegDAddress(cRegDAddress), .cRegDData(cRegDData), .hError(hError)
  );

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  bit          mBusy[32];
  int          mCount;
  logic [4:0]  mAddr;
  logic [31:0] mData;
  bit          mIsMem;
  bit          mErr;
  bit          modelValid = 0;
  bit          lastMemGrant;

  // DUT combinational outputs sampled just before the edge of the last cycle
  logic sAluRdy, sMemRdy, sBusy1, sBusy2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic rst, input logic aV, input logic [4:0] aA, input logic [31:0] aD,
                       input logic mV, input logic [4:0] mA, input logic [31:0] mD,
                       input logic kV, input logic [4:0] kA,
                       input logic [4:0] r1, input logic [4:0] r2);
    bit eA, eM, gA, gM;
    reset = rst; cAluValid = aV; cAluAddress = aA; cAluData = aD;
    cMemValid = mV; cMemAddress = mA; cMemData = mD;
    cMarkValid = kV; cMarkAddress = kA; cReg1Address = r1; cReg2Address = r2;
    #1;
    if (rst) begin
      eA = 0; eM = 0;
    end else if (LIMIT != 0 && mCount == LIMIT) begin
      eA = 1; eM = !aV;
    end else begin
      eM = mV; eA = !mV;
    end
    sAluRdy = hAluReady; sMemRdy = hMemReady; sBusy1 = hReg1Busy; sBusy2 = hReg2Busy;
    check("alu_ready", 32'(hAluReady), 32'(eA));
    check("mem_ready", 32'(hMemReady), 32'(eM));
    if (modelValid) begin
      check("reg1_busy", 32'(hReg1Busy), 32'(r1 != 0 && mBusy[r1]));
      check("reg2_busy", 32'(hReg2Busy), 32'(r2 != 0 && mBusy[r2]));
    end
    gA = aV && eA;
    gM = mV && eM;
    lastMemGrant = gM;
    @(posedge clock);
    if (rst) begin
      foreach (mBusy[i]) mBusy[i] = 0;
      mCount = 0; mAddr = 0; mData = 0; mIsMem = 0; mErr = 0; modelValid = 1;
    end else begin
      if (mIsMem && !mBusy[mAddr]) mErr = 1;
      if (kV && kA != 0 && mBusy[kA] && !(mIsMem && mAddr == kA)) mErr = 1;
      if (mIsMem) mBusy[mAddr] = 0;
      if (kV && kA != 0) mBusy[kA] = 1;
      if (!aV || gA) mCount = 0;
      else if (mCount < LIMIT) mCount++;
      if (gA) begin
        mAddr = aA; mData = aD; mIsMem = 0;
      end else if (gM) begin
        mAddr = mA; mData = mD; mIsMem = (mA != 0);
      end else begin
        mAddr = 0; mIsMem = 0;
      end
    end
    #1;
    if (modelValid) begin
      check("wr_addr", 32'(cRegDAddress), 32'(mAddr));
      if (mAddr != 0) check("wr_data", cRegDData, mData);
      check("error", 32'(hError), 32'(mErr));
    end
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, r1, r2);
  endtask

  task automatic do_reset();
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  logic [4:0] pend[$];

  initial begin
    logic aV, mV, kV;
    logic [4:0] aA, mA, kA, cand, held;
    logic [31:0] aD, mD;

    do_reset();
    do_reset();

    // ALU-only write of x5
    cycle(0, 1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
    check("t2_alu_ready", 32'(sAluRdy), 32'd1);
    check("t2_addr", 32'(cRegDAddress), 32'd5);
    check("t2_data", cRegDData, 32'h1234);
    idle(0, 0);
    check("t2_bubble", 32'(cRegDAddress), 32'd0);

    // Both sources valid every cycle: four Mem grants, then a forced ALU grant
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, 10, 32'(i), 1, 0, 32'(100 + i), 0, 0, 0, 0);
      check("t3_alu_grant", 32'(sAluRdy && !sMemRdy), 32'((i % 5) == 4));
      if ((i % 5) == 4) check("t3_alu_addr", 32'(cRegDAddress), 32'd10);
    end
    idle(0, 0);

    // Mark x7, load returns three cycles later
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    idle(7, 0);
    check("t4_busy_t1", 32'(sBusy1), 32'd1);
    idle(7, 0);
    check("t4_busy_t2", 32'(sBusy1), 32'd1);
    cycle(0, 0, 0, 0, 1, 7, 32'hCAFE, 0, 0, 7, 0);
    check("t4_busy_t3", 32'(sBusy1), 32'd1);
    check("t4_mem_ready", 32'(sMemRdy), 32'd1);
    idle(7, 0);
    check("t4_busy_t4", 32'(sBusy1), 32'd1);
    idle(0, 7);
    check("t4_clear_t5", 32'(sBusy2), 32'd0);
    check("t4_no_error", 32'(hError), 32'd0);

    // Re-mark x9 on the edge its first load commits: stays busy
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
    idle(0, 0);
    idle(0, 0);
    cycle(0, 0, 0, 0, 1, 9, 32'h99, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
    idle(9, 0);
    check("t5_still_busy", 32'(sBusy1), 32'd1);
    check("t5_no_error", 32'(hError), 32'd0);
    cycle(0, 0, 0, 0, 1, 9, 32'h98, 0, 0, 0, 0);
    idle(0, 0);
    idle(9, 0);
    check("t5_cleared", 32'(sBusy1), 32'd0);

    // x0 is never busy and never written; double mark of x3 is a sticky error
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(0, 0);
    check("t6_x0_busy", 32'(sBusy1), 32'd0);
    cycle(0, 0, 0, 0, 1, 0, 32'h55, 0, 0, 0, 0);
    check("t6_x0_addr", 32'(cRegDAddress), 32'd0);
    check("t6_x0_error", 32'(hError), 32'd0);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
    check("t6_error_set", 32'(hError), 32'd1);
    idle(3, 0);
    idle(0, 0);
    check("t6_error_sticky", 32'(hError), 32'd1);

    // Randomized traffic with well-formed mark/return pairs
    do_reset();
    for (int i = 0; i < 600; i++) begin
      aV = ($urandom_range(0, 9) < 6);
      aA = 5'($urandom_range(0, 31));
      aD = $urandom;
      mV = (pend.size() > 0) && ($urandom_range(0, 1) == 1);
      mA = mV ? pend[0] : 5'd0;
      mD = $urandom;
      kV = 0; kA = 0;
      if ($urandom_range(0, 9) < 3) begin
        cand = 5'($urandom_range(1, 31));
        if (!mBusy[cand]) begin
          kV = 1; kA = cand;
        end
      end
      cycle(0, aV, aA, aD, mV, mA, mD, kV, kA,
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      if (lastMemGrant) void'(pend.pop_front());
      if (kV) pend.push_back(kA);
    end
    check("rand_no_error", 32'(hError), 32'd0);

    // Reset with traffic in flight and a load pending
    held = 5'd12;
    if (mBusy[held]) begin
      idle(0, 0);
    end else begin
      cycle(0, 0, 0, 0, 0, 0, 0, 1, held, 0, 0);
    end
    cycle(1, 1, 4, 32'h77, 1, held, 32'h88, 0, 0, held, 0);
    check("t1_alu_ready_rst", 32'(sAluRdy), 32'd0);
    check("t1_mem_ready_rst", 32'(sMemRdy), 32'd0);
    check("t1_addr_rst", 32'(cRegDAddress), 32'd0);
    idle(held, held);
    check("t1_busy1", 32'(sBusy1), 32'd0);
    check("t1_busy2", 32'(sBusy2), 32'd0);
    check("t1_error", 32'(hError), 32'd0);
    check("t1_bubble", 32'(cRegDAddress), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
